// File: rtl/srlatch_dr_sequencer.sv
// Round-robin sequencer sharing one dual-rail SR-latch among N_REQ requesters.
// Optional watchdog on DRIVE/RELEASE enabled by defining SRLATCH_SEQ_TIMEOUT_EN.
module srlatch_dr_sequencer #(
  parameter int N_REQ       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_SPACER  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   cmd,
  output logic [N_REQ-1:0]     ack,
  output logic                 q,
  output logic                 busy,
  output logic                 err,
  output logic                 IPTG0,
  output logic                 IPTG1,
  output logic                 aTc0,
  output logic                 aTc1,
  input  logic                 GFP0,
  input  logic                 GFP1
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = $clog2(MIN_SPACER + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RELEASE, S_ACK} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          gnt_q, gnt_d;
  logic [1:0]             cmd_q, cmd_d;
  logic [SW-1:0]          spc_q, spc_d;
  logic                   q_q, q_d;
  logic                   err_q, err_d;
  logic [3:0]             rail_q, rail_d;  // {IPTG1, IPTG0, aTc1, aTc0}
  logic [SYNC_STAGES-1:0] s0_q, s1_q;
  logic                   gs0, gs1;
  logic                   hit;
  logic [IW-1:0]          pick;
  logic                   tmo_hit;

  function automatic logic [3:0] codeword(input logic [1:0] c);
    case (c)
      2'b01:   codeword = 4'b1001;
      2'b10:   codeword = 4'b0110;
      default: codeword = 4'b0101;
    endcase
  endfunction

  function automatic logic expect_q(input logic [1:0] c, input logic prev);
    case (c)
      2'b01:   expect_q = 1'b1;
      2'b10:   expect_q = 1'b0;
      default: expect_q = prev;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q <= {s0_q[SYNC_STAGES-2:0], GFP0};
      s1_q <= {s1_q[SYNC_STAGES-2:0], GFP1};
    end
  end

  assign gs0 = s0_q[SYNC_STAGES-1];
  assign gs1 = s1_q[SYNC_STAGES-1];

  // Scan downwards so the requester closest to the pointer is the last writer.
  always_comb begin
    hit  = 1'b0;
    pick = ptr_q;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr_q) + i) % N_REQ]) begin
        hit  = 1'b1;
        pick = IW'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

`ifdef SRLATCH_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = tmo_q + 1'b1;
    if (state_d != state_q || state_q == S_IDLE || state_q == S_ACK) tmo_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cmd_d   = cmd_q;
    q_d     = q_q;
    err_d   = err_q;
    rail_d  = rail_q;
    spc_d   = spc_q;
    if (rail_q == 4'b0000 && spc_q < SW'(MIN_SPACER)) spc_d = spc_q + 1'b1;
    if (gs0 && gs1) err_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (hit && spc_q >= SW'(MIN_SPACER)) begin
          gnt_d   = pick;
          cmd_d   = cmd[2*int'(pick) +: 2];
          rail_d  = codeword(cmd[2*int'(pick) +: 2]);
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (gs0 ^ gs1) begin
          q_d = gs1;
          if (gs1 != expect_q(cmd_q, q_q)) err_d = 1'b1;
          rail_d  = 4'b0000;
          state_d = S_RELEASE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          rail_d  = 4'b0000;
          state_d = S_ACK;
        end
      end
      S_RELEASE: begin
        if (!gs0 && !gs1) begin
          state_d = S_ACK;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        ptr_d   = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
        spc_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cmd_q   <= '0;
      spc_q   <= SW'(MIN_SPACER);
      q_q     <= 1'b0;
      err_q   <= 1'b0;
      rail_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cmd_q   <= cmd_d;
      spc_q   <= spc_d;
      q_q     <= q_d;
      err_q   <= err_d;
      rail_q  <= rail_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == S_ACK) ack = N_REQ'(1) << gnt_q;
  end

  assign {IPTG1, IPTG0, aTc1, aTc0} = rail_q;
  assign q    = q_q;
  assign err  = err_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_srlatch_dr_sequencer.sv
// Bench for srlatch_dr_sequencer: behavioural latch model plus transaction-level
// reference (round-robin choice, codeword, expected q/err) with random stimulus.
module tb_srlatch_dr_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = '0;
  logic [3:0] cmd = '0;
  logic [1:0] ack;
  logic       q, busy, err;
  logic       IPTG0, IPTG1, aTc0, aTc1;
  logic       GFP0 = 1'b0;
  logic       GFP1 = 1'b0;
  logic [3:0] rails;

  int n_vec = 0;
  int n_err = 0;
  int tb_ptr = 0;
  logic pred_q = 1'b0;

  srlatch_dr_sequencer #(
    .N_REQ(2), .SYNC_STAGES(2), .MIN_SPACER(4), .TIMEOUT_CYC(1024)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .cmd(cmd), .ack(ack),
    .q(q), .busy(busy), .err(err),
    .IPTG0(IPTG0), .IPTG1(IPTG1), .aTc0(aTc0), .aTc1(aTc1),
    .GFP0(GFP0), .GFP1(GFP1)
  );

  always #5 clk = ~clk;

  assign rails = {IPTG1, IPTG0, aTc1, aTc0};

  // Latch model: mode 0 behaves as a real SR latch, 1 always answers GFP1, 2 never answers.
  int   m_mode = 0;
  int   m_dly = 5;
  int   m_cnt = 0;
  logic m_state = 1'b0;

  function automatic logic latch_next(input logic [3:0] r, input logic st, input int mode);
    if (mode == 1) return 1'b1;
    if (r[3] && r[0]) return 1'b1;
    if (r[2] && r[1]) return 1'b0;
    return st;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      GFP0 <= 1'b0; GFP1 <= 1'b0; m_cnt <= 0;
    end else if (rails == 4'b0000) begin
      GFP0 <= 1'b0; GFP1 <= 1'b0; m_cnt <= 0;
    end else if (m_cnt < m_dly) begin
      m_cnt <= m_cnt + 1;
    end else if (m_mode != 2 && !GFP0 && !GFP1) begin
      GFP1    <= latch_next(rails, m_state, m_mode);
      GFP0    <= !latch_next(rails, m_state, m_mode);
      m_state <= latch_next(rails, m_state, m_mode);
    end
  end

  // Monitors: overlapping ack bits and shortest all-zero run from an ack to the next codeword.
  int ack_multi = 0;
  int min_gap = 1000;
  int gap_run = 0;
  bit gap_arm = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      gap_arm = 1'b0;
    end else begin
      if ($countones(ack) > 1) ack_multi++;
      if (gap_arm && rails != 4'b0000) begin
        if (gap_run < min_gap) min_gap = gap_run;
        gap_arm = 1'b0;
      end else if (gap_arm) begin
        gap_run++;
      end
      if (ack != 2'b00) begin
        gap_arm = 1'b1;
        gap_run = 0;
      end
    end
  end

  function automatic logic [3:0] want_cw(input logic [1:0] c);
    if (c == 2'b01) return 4'b1001;
    if (c == 2'b10) return 4'b0110;
    return 4'b0101;
  endfunction

  task automatic wait_ack(input int budget, output logic [1:0] av, output logic [3:0] cw,
                          output bit ok);
    int c;
    ok = 1'b0; av = '0; cw = '0; c = 0;
    while (!ok && c < budget) begin
      @(negedge clk);
      if (cw == 4'b0000 && rails != 4'b0000) cw = rails;
      if (ack != 2'b00) begin
        av = ack;
        ok = 1'b1;
      end
      c++;
    end
  endtask

  task automatic test_reset();
    int busy_seen;
    reset = 1'b1; req = '0; cmd = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (rails !== 4'b0000) begin n_err++; $display("FAIL reset_rails: got %b want 0000", rails); end
    n_vec++; if (ack !== 2'b00) begin n_err++; $display("FAIL reset_ack: got %b want 00", ack); end
    n_vec++; if (q !== 1'b0) begin n_err++; $display("FAIL reset_q: got %b want 0", q); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    reset = 1'b0; tb_ptr = 0; pred_q = 1'b0;
    busy_seen = 0;
    repeat (6) begin @(negedge clk); if (busy !== 1'b0) busy_seen++; end
    n_vec++; if (busy_seen != 0) begin n_err++; $display("FAIL idle_no_req: busy cycles %0d want 0", busy_seen); end
  endtask

  task automatic test_set_reset();
    logic [1:0] av; logic [3:0] cw; bit ok;
    m_mode = 0; m_dly = 5;
    req = 2'b01; cmd = 4'b0001;
    wait_ack(200, av, cw, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL set_timeout: no ack within 200 cycles"); end
    n_vec++; if (av !== 2'b01) begin n_err++; $display("FAIL set_ack: got %b want 01", av); end
    n_vec++; if (cw !== 4'b1001) begin n_err++; $display("FAIL set_codeword: got %b want 1001", cw); end
    n_vec++; if (q !== 1'b1) begin n_err++; $display("FAIL set_q: got %b want 1", q); end
    n_vec++; if (rails !== 4'b0000) begin n_err++; $display("FAIL set_rails_at_ack: got %b want 0000", rails); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL set_err: got %b want 0", err); end
    req = 2'b10; cmd = 4'b1000;
    wait_ack(200, av, cw, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rst_timeout: no ack within 200 cycles"); end
    n_vec++; if (av !== 2'b10) begin n_err++; $display("FAIL rst_ack: got %b want 10", av); end
    n_vec++; if (cw !== 4'b0110) begin n_err++; $display("FAIL rst_codeword: got %b want 0110", cw); end
    n_vec++; if (q !== 1'b0) begin n_err++; $display("FAIL rst_q: got %b want 0", q); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
    n_vec++; if (min_gap < 4) begin n_err++; $display("FAIL spacer_gap: got %0d want >=4", min_gap); end
    req = 2'b00; tb_ptr = 0; pred_q = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] av; logic [3:0] cw; bit ok;
    logic exp_q;
    req = 2'b11; cmd = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_ack(200, av, cw, ok);
      exp_q = (tb_ptr == 0);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rr_timeout[%0d]: no ack", k); end
      n_vec++; if (av !== 2'(1 << tb_ptr)) begin n_err++; $display("FAIL rr_ack[%0d]: got %b want %b", k, av, 2'(1 << tb_ptr)); end
      n_vec++; if (q !== exp_q) begin n_err++; $display("FAIL rr_q[%0d]: got %b want %b", k, q, exp_q); end
      pred_q = exp_q;
      tb_ptr = (tb_ptr + 1) % 2;
    end
    req = 2'b00;
    n_vec++; if (ack_multi != 0) begin n_err++; $display("FAIL rr_ack_overlap: got %0d want 0", ack_multi); end
    n_vec++; if (min_gap < 4) begin n_err++; $display("FAIL rr_spacer_gap: got %0d want >=4", min_gap); end
  endtask

  task automatic test_random();
    logic [1:0] av; logic [3:0] cw; bit ok;
    logic [1:0] mask, gc; logic [3:0] c; logic exp_q;
    int g;
    m_mode = 0;
    for (int k = 0; k < 12; k++) begin
      mask  = 2'($urandom_range(1, 3));
      c     = 4'($urandom);
      m_dly = $urandom_range(1, 8);
      g = mask[tb_ptr] ? tb_ptr : (tb_ptr + 1) % 2;
      gc = c[2*g +: 2];
      exp_q = (gc == 2'b01) ? 1'b1 : (gc == 2'b10) ? 1'b0 : pred_q;
      req = mask; cmd = c;
      wait_ack(300, av, cw, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rnd_timeout[%0d]: no ack", k); end
      n_vec++; if (av !== 2'(1 << g)) begin n_err++; $display("FAIL rnd_ack[%0d]: got %b want %b", k, av, 2'(1 << g)); end
      n_vec++; if (cw !== want_cw(gc)) begin n_err++; $display("FAIL rnd_codeword[%0d]: got %b want %b", k, cw, want_cw(gc)); end
      n_vec++; if (q !== exp_q) begin n_err++; $display("FAIL rnd_q[%0d]: got %b want %b", k, q, exp_q); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rnd_err[%0d]: got %b want 0", k, err); end
      req = 2'b00;
      pred_q = exp_q;
      tb_ptr = (g + 1) % 2;
    end
    n_vec++; if (ack_multi != 0) begin n_err++; $display("FAIL rnd_ack_overlap: got %0d want 0", ack_multi); end
    n_vec++; if (min_gap < 4) begin n_err++; $display("FAIL rnd_spacer_gap: got %0d want >=4", min_gap); end
  endtask

  task automatic test_hold();
    logic [1:0] av; logic [3:0] cw; bit ok;
    m_mode = 0; m_dly = 3;
    req = 2'(1 << tb_ptr); cmd = (tb_ptr == 0) ? 4'b0010 : 4'b1000;
    wait_ack(200, av, cw, ok);
    n_vec++; if (q !== 1'b0 || !ok) begin n_err++; $display("FAIL hold_prep_q: got %b want 0", q); end
    tb_ptr = (tb_ptr + 1) % 2;
    req = 2'(1 << tb_ptr); cmd = 4'b0000;
    wait_ack(200, av, cw, ok);
    n_vec++; if (cw !== 4'b0101) begin n_err++; $display("FAIL hold_codeword: got %b want 0101", cw); end
    n_vec++; if (q !== 1'b0) begin n_err++; $display("FAIL hold_q: got %b want 0", q); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL hold_err: got %b want 0", err); end
    tb_ptr = (tb_ptr + 1) % 2;
    m_mode = 1;
    req = 2'(1 << tb_ptr); cmd = 4'b1111;
    wait_ack(200, av, cw, ok);
    n_vec++; if (cw !== 4'b0101) begin n_err++; $display("FAIL hold_bad_codeword: got %b want 0101", cw); end
    n_vec++; if (q !== 1'b1) begin n_err++; $display("FAIL hold_bad_q: got %b want 1", q); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL hold_bad_err: got %b want 1", err); end
    tb_ptr = (tb_ptr + 1) % 2;
    m_mode = 0;
    req = 2'(1 << tb_ptr); cmd = 4'b0101;
    wait_ack(200, av, cw, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL sticky_timeout: no ack"); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err); end
    tb_ptr = (tb_ptr + 1) % 2;
    req = 2'b00;
  endtask

  task automatic test_reset_mid();
    logic [1:0] av; logic [3:0] cw; bit ok;
    int c, ack_during;
    m_mode = 2; m_dly = 2;
    req = 2'b01; cmd = 4'b0001;
    c = 0;
    while (rails == 4'b0000 && c < 50) begin @(negedge clk); c++; end
    n_vec++; if (rails !== 4'b1001) begin n_err++; $display("FAIL mid_drive_rails: got %b want 1001", rails); end
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    #1;
    n_vec++; if (rails !== 4'b0000) begin n_err++; $display("FAIL mid_rails_on_reset: got %b want 0000", rails); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy_on_reset: got %b want 0", busy); end
    ack_during = 0;
    repeat (3) begin @(negedge clk); if (ack !== 2'b00) ack_during++; end
    n_vec++; if (ack_during != 0) begin n_err++; $display("FAIL mid_ack_in_reset: got %0d want 0", ack_during); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL mid_err_cleared: got %b want 0", err); end
    m_mode = 0;
    reset = 1'b0; tb_ptr = 0;
    wait_ack(200, av, cw, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL mid_reserve_timeout: no ack"); end
    n_vec++; if (av !== 2'b01) begin n_err++; $display("FAIL mid_reserve_ack: got %b want 01", av); end
    n_vec++; if (cw !== 4'b1001) begin n_err++; $display("FAIL mid_reserve_codeword: got %b want 1001", cw); end
    n_vec++; if (q !== 1'b1) begin n_err++; $display("FAIL mid_reserve_q: got %b want 1", q); end
    req = 2'b00;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_set_reset();
    test_round_robin();
    test_random();
    test_hold();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/srlatch_dr_sequencer.md
Name: srlatch_dr_sequencer

Overview:
- Clocked controller that sequences and shares one dual-rail SR-latch genetic circuit (inputs IPTG0/IPTG1/aTc0/aTc1, outputs GFP0/GFP1) among N_REQ requesters.
- Arbitrates round-robin and encodes each command as a dual-rail codeword.
- Waits for a valid GFP completion, returns the rails to the all-zero spacer, waits for GFP to clear, then acknowledges.
- Sits between the synchronous test/control fabric and the asynchronous latch model.

Parameters:
- N_REQ, 2, number of requesters (1..8).
- SYNC_STAGES, 2, flops in each GFP input synchronizer (>=2).
- MIN_SPACER, 4, minimum cycles rails stay all-zero between codewords (>=1).
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request level; held until ack.
- cmd  input  2*N_REQ  per-requester command, slice i = cmd[2i+1:2i]; 01 set, 10 reset, 00/11 hold.
- ack  output  N_REQ  one-cycle completion pulse to the granted requester.
- q  output  1  last latch value captured from GFP.
- busy  output  1  high whenever not in IDLE.
- err  output  1  sticky protocol error.
- IPTG0, IPTG1, aTc0, aTc1  output  1 each  dual-rail drive to the latch; registered.
- GFP0, GFP1  input  1 each  asynchronous latch outputs; synchronized internally.

Behaviour:
- Reset values: all rails 0, ack 0, q 0, busy 0, err 0, round-robin pointer 0, spacer counter = MIN_SPACER (satisfied), state IDLE.
- Reset mid-operation: rails drop to 0 on the reset edge, no ack is issued, and the pending request is re-arbitrated after reset.
- Codewords (registered, applied one cycle after grant):
  - set: IPTG1=1, aTc0=1.
  - reset: IPTG0=1, aTc1=1.
  - hold: IPTG0=1, aTc0=1.
  - Never more than one rail per pair is high.
- Synchronization: gs0/gs1 are the SYNC_STAGES-flop synchronized GFP0/GFP1. All decisions use gs0/gs1 only.
- IDLE:
  - If any req bit is set and the spacer counter >= MIN_SPACER, grant the first set req at or after the pointer (wrapping modulo N_REQ).
  - Latch that requester's cmd and index, then go to DRIVE.
  - Otherwise stay in IDLE.
- DRIVE:
  - Rails carry the codeword.
  - Wait for exactly one of gs0/gs1 high. Then set q = gs1, check it against the expected value, and go to RELEASE.
  - Expected value: set -> 1, reset -> 0, hold -> previous q.
  - A mismatch sets err; the transaction still completes.
  - gs0 and gs1 both high in any state sets err; DRIVE keeps waiting.
- RELEASE: rails go to 0 on entry. Wait for gs0=0 and gs1=0, then go to ACK.
- ACK:
  - ack[grant]=1 for exactly one cycle.
  - Pointer = grant+1 (wraps to 0 after N_REQ-1).
  - Spacer counter cleared to 0.
  - Next state IDLE.
- Spacer counter increments while rails are all 0, saturating at MIN_SPACER. This is what enforces the minimum return-to-zero gap between back-to-back codewords.
- Simultaneous requests: the round-robin pointer decides. A requester that was just served has lowest priority next time.
- req/cmd changes after the grant are ignored until ack.
- Latency, rails change to ack: 1 cycle (rails registered) + SYNC_STAGES (rise) + 1 (RELEASE) + SYNC_STAGES (fall) + 1 (ACK), plus the latch response time.
- err clears only on reset.

Optional Feature:
- Macro: SRLATCH_SEQ_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in DRIVE and RELEASE and clears on each state entry.
  - When the count reaches TIMEOUT_CYC: set err, force rails to 0, go to ACK, and leave q unchanged.
  - In RELEASE, the timeout also proceeds to ACK.
- When not defined: no counter is built, and DRIVE/RELEASE wait indefinitely.

Test Plan:
- Reset, then req[0]=1 with cmd0=01, latch model raising GFP1 5 cycles after IPTG1&aTc0 -> IPTG1=aTc0=1; q=1; rails 0; after GFP1 falls, one ack[0] pulse; err=0.
- req[1]=1 with cmd1=10 following q=1 -> IPTG0=aTc1=1; GFP0 response; q=0; ack[1] pulse; the next codeword does not start until rails have been 0 for >=4 cycles.
- req=2'b11 held continuously with cmd0=01 and cmd1=10 -> grants alternate 0,1,0,1; ack pulses never overlap; q toggles 1,0,1,0.
- Hold command (00) with q=0 and the model returning GFP0 -> IPTG0=aTc0=1; q stays 0, err=0. Same command with the model returning GFP1 -> err=1 (sticky).
- Assert reset while in DRIVE -> rails 0 and busy 0 immediately, no ack; after release, the held req is re-served.
- With SRLATCH_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16, model never responds -> after 16 cycles in DRIVE, rails go to 0, err=1, ack pulses, q unchanged.
